// File: rtl/multdiv_unit_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_unit_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = 6;

  localparam logic [WIDTH_DEF-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/multdiv_unit_negate_w.sv
// Two's-complement conditional negator: o_data_c = i_neg ? -i_data : i_data.
module negate_w #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_data,
  input  logic         i_neg,
  output logic [W-1:0] o_data_c
);

  assign o_data_c = i_neg ? (~i_data + W'(1)) : i_data;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring), one bit per cycle,
// result + exception + one-cycle ready pulse WIDTH+1 cycles after the start strobe.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;      // product high half / partial remainder
  logic [WIDTH-1:0]   r_lo;      // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0]   r_b;       // multiplicand / divisor magnitude
  logic               r_neg;
  logic               r_is_div;
  logic               r_bzero;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_start;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quot_s;
  logic [WIDTH:0]     w_prod_top;
  logic               w_mul_ovf;
  logic               w_div_ovf;
  logic               w_last;

  negate_w #(.W(WIDTH)) u_neg_a (
    .i_data   (data_operandA),
    .i_neg    (data_operandA[WIDTH-1]),
    .o_data_c (w_a_mag)
  );

  negate_w #(.W(WIDTH)) u_neg_b (
    .i_data   (data_operandB),
    .i_neg    (data_operandB[WIDTH-1]),
    .o_data_c (w_b_mag)
  );

  negate_w #(.W(2*WIDTH)) u_neg_prod (
    .i_data   ({r_hi, r_lo}),
    .i_neg    (r_neg),
    .o_data_c (w_prod_s)
  );

  negate_w #(.W(WIDTH)) u_neg_quot (
    .i_data   (r_lo),
    .i_neg    (r_neg),
    .o_data_c (w_quot_s)
  );

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  // Multiply step: conditionally add multiplicand into the high half, then shift right.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

  // Divide step: shift next dividend bit into the remainder and trial-subtract.
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  // Overflow when the signed product is not the sign extension of its low half.
  assign w_prod_top = w_prod_s[2*WIDTH-1:WIDTH-1];
  assign w_mul_ovf  = ~((&w_prod_top) | ~(|w_prod_top));

  // Only INT_MIN / -1 yields a positive quotient of magnitude 2^(WIDTH-1).
  assign w_div_ovf  = r_lo[WIDTH-1] & ~r_neg;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_b            <= '0;
      r_neg          <= 1'b0;
      r_is_div       <= 1'b0;
      r_bzero        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (w_start) begin
        // A new strobe always wins, silently aborting anything in flight.
        r_state  <= ctrl_MULT ? MUL : DIV;
        r_cnt    <= '0;
        r_hi     <= '0;
        r_lo     <= w_a_mag;
        r_b      <= w_b_mag;
        r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_is_div <= ~ctrl_MULT;
        r_bzero  <= (data_operandB == '0);
        busy     <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            busy <= 1'b0;
          end
          MUL: begin
            r_hi  <= w_sum[WIDTH:1];
            r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_state <= DONE;
          end
          DIV: begin
            if (w_diff[WIDTH]) begin
              r_hi <= w_shift[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end else begin
              r_hi <= w_diff[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_state <= DONE;
          end
          DONE: begin
            if (r_is_div) begin
              data_result    <= r_bzero ? '0 : w_quot_s;
              data_exception <= r_bzero | w_div_ovf;
            end else begin
              data_result    <= w_prod_s[WIDTH-1:0];
              data_exception <= w_mul_ovf;
            end
            data_resultRDY <= 1'b1;
            r_state        <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit: latency, signs, exceptions,
// restart, simultaneous strobes and reset behaviour.
module tb_multdiv_unit;
  import multdiv_unit_pkg::*;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         ctrl_MULT;
  logic         ctrl_DIV;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  multdiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle strobe; returns at the negedge just after the sampling edge.
  task automatic strobe(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Expect exactly W quiet busy cycles, then a single ready pulse with the given result.
  task automatic expect_done(input string tag, input logic [W-1:0] exp_res, input logic exp_exc);
    logic         early;
    logic         idle;
    logic         moved;
    logic [W-1:0] held;
    early = data_resultRDY;
    idle  = ~busy;
    moved = 1'b0;
    held  = data_result;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clock);
      early |= data_resultRDY;
      idle  |= ~busy;
      moved |= (data_result !== held);
    end
    check({tag, "_no_early_rdy"}, W'(early), W'(0));
    check({tag, "_busy_held"},    W'(idle),  W'(0));
    check({tag, "_result_held"},  W'(moved), W'(0));
    @(negedge clock);
    check({tag, "_rdy"},    W'(data_resultRDY), W'(1));
    check({tag, "_result"}, data_result,        exp_res);
    check({tag, "_exc"},    W'(data_exception), W'(exp_exc));
    check({tag, "_busy_at_rdy"}, W'(busy), W'(1));
    @(negedge clock);
    check({tag, "_rdy_drop"},  W'(data_resultRDY), W'(0));
    check({tag, "_busy_drop"}, W'(busy),           W'(0));
  endtask

  task automatic run(input string tag, input logic m, input logic d,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp_res, input logic exp_exc);
    strobe(m, d, a, b);
    expect_done(tag, exp_res, exp_exc);
  endtask

  initial begin
    logic seen;
    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd2;
    data_operandB = 32'd3;
    repeat (3) @(negedge clock);
    // Strobe held during reset must be ignored.
    check("reset_result", data_result,        '0);
    check("reset_exc",    W'(data_exception), W'(0));
    check("reset_rdy",    W'(data_resultRDY), W'(0));
    check("reset_busy",   W'(busy),           W'(0));
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    repeat (2) @(negedge clock);
    check("strobe_in_reset_ignored", W'(busy), W'(0));

    run("mul_7x-6",      1'b1, 1'b0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
    run("mul_ovf",       1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run("mul_max_x1",    1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 1'b0);
    run("mul_min_x1",    1'b1, 1'b0, INT_MIN,       32'd1,         INT_MIN,       1'b0);
    run("mul_min_xm1",   1'b1, 1'b0, INT_MIN,       32'hFFFF_FFFF, INT_MIN,       1'b1);
    run("div_m43_5",     1'b0, 1'b1, 32'hFFFF_FFD5, 32'd5,         32'hFFFF_FFF8, 1'b0);
    run("div_43_m5",     1'b0, 1'b1, 32'd43,        32'hFFFF_FFFB, 32'hFFFF_FFF8, 1'b0);
    run("div_m43_m5",    1'b0, 1'b1, 32'hFFFF_FFD5, 32'hFFFF_FFFB, 32'd8,         1'b0);
    run("div_by_zero",   1'b0, 1'b1, 32'd100,       32'd0,         32'd0,         1'b1);
    run("div_min_m1",    1'b0, 1'b1, INT_MIN,       32'hFFFF_FFFF, INT_MIN,       1'b1);
    run("both_strobes",  1'b1, 1'b1, 32'd6,         32'd3,         32'd18,        1'b0);

    // Restart: divide issued mid-multiply; the multiply never reports.
    strobe(1'b1, 1'b0, 32'd7, 32'd6);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      seen |= data_resultRDY;
    end
    check("restart_pre_quiet", W'(seen), W'(0));
    strobe(1'b0, 1'b1, 32'd9, 32'd3);
    expect_done("restart_div", 32'd3, 1'b0);

    // Reset mid-multiply clears everything and suppresses the ready pulse.
    strobe(1'b1, 1'b0, 32'd5, 32'd7);
    repeat (13) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_result", data_result,        '0);
    check("midrst_exc",    W'(data_exception), W'(0));
    check("midrst_rdy",    W'(data_resultRDY), W'(0));
    check("midrst_busy",   W'(busy),           W'(0));
    reset = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen |= data_resultRDY | busy;
    end
    check("midrst_no_rdy", W'(seen), W'(0));
    run("post_rst_2x3", 1'b1, 1'b0, 32'd2, 32'd3, 32'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
Iterative signed multiply/divide unit and the sequential counterpart to the single-cycle ALU. The execute stage presents the same operand pair plus a one-cycle start strobe. The unit returns the result, an exception flag and a one-cycle ready pulse a fixed number of cycles later. The processor stalls on it for mul/div instructions.

Parameters:
WIDTH, 32, operand and result width in bits
CNT_W, 6, iteration counter width; must hold WIDTH+1

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
data_operandA  in  WIDTH  multiplicand / dividend, signed two's complement
data_operandB  in  WIDTH  multiplier / divisor, signed two's complement
ctrl_MULT  in  1  start-multiply strobe, one cycle
ctrl_DIV  in  1  start-divide strobe, one cycle
data_result  out  WIDTH  low WIDTH bits of product, or quotient
data_exception  out  1  overflow or divide-by-zero flag, valid with ready
data_resultRDY  out  1  one-cycle pulse: result valid
busy  out  1  high while an operation is in flight

Behaviour:
- Interface: one clock domain (clock); reset is synchronous and active-high.
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, state=IDLE, counter=0.
- States:
  - IDLE → MUL on ctrl_MULT, or IDLE → DIV on ctrl_DIV.
  - MUL/DIV → DONE after WIDTH iterations.
  - DONE → IDLE.
  - A start in DONE moves directly to MUL/DIV.
- Start capture: the edge that samples a strobe latches A and B into internal registers and clears the counter. Operand inputs are don't-care afterwards.
- Simultaneous strobes: ctrl_MULT and ctrl_DIV in the same cycle → multiply wins.
- Start while busy: the in-flight operation is aborted silently (no ready pulse) and the new one restarts with fresh operands.
- Multiply:
  - Radix-2 shift-add on operand magnitudes, one bit per cycle, WIDTH cycles.
  - Sign applied at the end: negate if signs differ.
  - Full 2*WIDTH-bit product formed internally.
  - data_exception=1 if the 2*WIDTH product is not the sign-extension of its low WIDTH bits.
  - data_result always equals the low WIDTH bits.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles.
  - Quotient truncates toward zero; sign = signA XOR signB. Remainder is discarded.
  - Divisor == 0: data_result=0, data_exception=1. The full latency still applies.
  - A=0x80000000, B=0xFFFFFFFF: data_result=0x80000000, data_exception=1.
- Latency: strobe sampled at edge t. Iterations occur on edges t+1..t+WIDTH. data_result, data_exception and data_resultRDY register at edge t+WIDTH+1 (33 for WIDTH=32).
- data_resultRDY is high exactly one cycle.
- busy is high from edge t through the RDY cycle inclusive.
- data_result and data_exception hold their values until the next RDY; they do not change during iteration.
- Reset mid-operation returns to reset values next edge with no RDY. A strobe coincident with reset is ignored.

Decomposition:
- Shared defines include: state encodings (IDLE, MUL, DIV, DONE), WIDTH default, and the INT_MIN constant.
- One sub-module: negate_w, a WIDTH-bit two's-complement conditional negator (out = neg ? ~in+1 : in). It is instantiated for operand magnitude and result sign fix-up.
- The adder/subtractor for partial products and remainders is inline.

Test Plan:
- Multiply 7 × -6: ctrl_MULT, A=7, B=0xFFFFFFFA → 33 cycles later RDY=1, result=0xFFFFFFD6, exception=0; RDY low the next cycle.
- Multiply overflow: A=0x00010000, B=0x00010000 → result=0x00000000, exception=1. Separately, 0x7FFFFFFF × 1 → result=0x7FFFFFFF, exception=0.
- Divide -43 / 5: A=0xFFFFFFD5, B=5 → result=0xFFFFFFF8 (-8), exception=0. Separately, 43 / -5 → result=0xFFFFFFF8.
- Divide-by-zero and overflow:
  - 100 / 0 → result=0, exception=1, at 33 cycles.
  - 0x80000000 / 0xFFFFFFFF → result=0x80000000, exception=1.
- Restart and simultaneous strobes:
  - ctrl_MULT 7×6; at cycle 10, ctrl_DIV 9/3 → no RDY at cycle 33; a single RDY 33 cycles after the DIV strobe with result=3.
  - ctrl_MULT and ctrl_DIV together with A=6, B=3 → result=18.
- Reset mid-operation: assert reset at cycle 15 of a multiply → all outputs 0 and no RDY. A new 2×3 then completes with result=6 after 33 cycles.
